// File: rtl/axi_reg_bridge.sv
// AXI4 slave to single-beat register bus bridge. Bursts are serialised into
// register accesses; one transaction in flight, read data sampled one clock after the address.
module axi_reg_bridge #(
   parameter int unsigned ID_WIDTH = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [ID_WIDTH-1:0] i_awid,
   input  logic [31:0]         i_awaddr,
   input  logic [7:0]          i_awlen,
   input  logic [2:0]          i_awsize,
   input  logic [1:0]          i_awburst,
   input  logic                i_awvalid,
   output logic                o_awready,
   input  logic [ID_WIDTH-1:0] i_arid,
   input  logic [31:0]         i_araddr,
   input  logic [7:0]          i_arlen,
   input  logic [2:0]          i_arsize,
   input  logic [1:0]          i_arburst,
   input  logic                i_arvalid,
   output logic                o_arready,
   input  logic [63:0]         i_wdata,
   input  logic [7:0]          i_wstrb,
   input  logic                i_wlast,
   input  logic                i_wvalid,
   output logic                o_wready,
   output logic [ID_WIDTH-1:0] o_bid,
   output logic [1:0]          o_bresp,
   output logic                o_bvalid,
   input  logic                i_bready,
   output logic [ID_WIDTH-1:0] o_rid,
   output logic [63:0]         o_rdata,
   output logic [1:0]          o_rresp,
   output logic                o_rlast,
   output logic                o_rvalid,
   input  logic                i_rready,
   output logic                o_reg_we,
   output logic [31:0]         o_reg_addr,
   output logic [7:0]          o_reg_be,
   output logic [63:0]         o_reg_wdata,
   input  logic [63:0]         i_reg_rdata
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA
   } state_t;

   state_t state, state_next;

   logic [ID_WIDTH-1:0] id;
   logic [31:0]         addr;
   logic [31:0]         next_addr;
   logic [7:0]          len;
   logic [2:0]          size;
   logic [1:0]          burst;
   logic [8:0]          beat;
   logic                err;
   logic                prio_wr;

   logic aw_grant, ar_grant;
   logic aw_hs, ar_hs, w_hs, r_hs;
   logic last_beat, wr_done;

   assign o_bid = id;
   assign o_rid = id;

   always_comb begin
      aw_grant   = i_awvalid && (!i_arvalid || prio_wr);
      ar_grant   = i_arvalid && (!i_awvalid || !prio_wr);
      last_beat  = (beat == {1'b0, len});
      wr_done    = (beat == ({1'b0, len} + 9'd1));
      next_addr  = (burst == BURST_FIXED) ? addr : addr + (32'd1 << size);

      state_next = state;
      o_awready  = 1'b0;
      o_arready  = 1'b0;
      o_wready   = 1'b0;
      o_bvalid   = 1'b0;
      o_bresp    = RESP_OKAY;
      o_rvalid   = 1'b0;
      o_rresp    = RESP_OKAY;
      o_rlast    = 1'b0;

      case (state)
         IDLE: begin
            o_awready = aw_grant;
            o_arready = ar_grant;
            if (aw_grant)      state_next = WR_DATA;
            else if (ar_grant) state_next = RD_ADDR;
         end
         // The final beat's strobe is issued from WR_DATA; WR_RESP follows once the
         // counter reaches len+1, so no write strobe ever overlaps the B response.
         WR_DATA: begin
            o_wready = !wr_done;
            if (wr_done) state_next = WR_RESP;
         end
         WR_RESP: begin
            o_bvalid = 1'b1;
            o_bresp  = err ? RESP_SLVERR : RESP_OKAY;
            if (i_bready) state_next = IDLE;
         end
         RD_ADDR: state_next = RD_DATA;
         RD_DATA: begin
            o_rvalid = 1'b1;
            o_rresp  = err ? RESP_SLVERR : RESP_OKAY;
            o_rlast  = last_beat;
            if (i_rready) state_next = last_beat ? IDLE : RD_ADDR;
         end
         default: state_next = IDLE;
      endcase

      aw_hs = i_awvalid && o_awready;
      ar_hs = i_arvalid && o_arready;
      w_hs  = i_wvalid && o_wready;
      r_hs  = o_rvalid && i_rready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id          <= '0;
         addr        <= '0;
         len         <= '0;
         size        <= '0;
         burst       <= '0;
         beat        <= '0;
         err         <= 1'b0;
         prio_wr     <= 1'b1;
         o_reg_we    <= 1'b0;
         o_reg_addr  <= '0;
         o_reg_be    <= '0;
         o_reg_wdata <= '0;
         o_rdata     <= '0;
      end else begin
         o_reg_we <= 1'b0;

         if (aw_hs) begin
            id      <= i_awid;
            addr    <= i_awaddr;
            len     <= i_awlen;
            size    <= i_awsize;
            burst   <= i_awburst;
            beat    <= '0;
            err     <= (i_awburst == BURST_RSVD);
            prio_wr <= 1'b0;
         end else if (ar_hs) begin
            id         <= i_arid;
            addr       <= i_araddr;
            len        <= i_arlen;
            size       <= i_arsize;
            burst      <= i_arburst;
            beat       <= '0;
            err        <= (i_arburst == BURST_RSVD);
            prio_wr    <= 1'b1;
            o_reg_addr <= i_araddr & ~32'h7;
         end

         if (w_hs) begin
            o_reg_we    <= 1'b1;
            o_reg_addr  <= addr & ~32'h7;
            o_reg_be    <= i_wstrb;
            o_reg_wdata <= i_wdata;
            addr        <= next_addr;
            beat        <= beat + 9'd1;
            if (i_wlast != last_beat) err <= 1'b1;
         end

         if (state == RD_ADDR) o_rdata <= i_reg_rdata;

         if (r_hs) begin
            addr       <= next_addr;
            beat       <= beat + 9'd1;
            o_reg_addr <= next_addr & ~32'h7;
         end
      end
   end

endmodule

// File: tb/tb_axi_reg_bridge.sv
// Bench for axi_reg_bridge: drivers push expected register writes, B and R beats
// into queues; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_axi_reg_bridge;
   localparam int IDW = 2;
   localparam int TMO = 50;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [IDW-1:0] awid, arid, bid, rid;
   logic [31:0]    awaddr, araddr, reg_addr;
   logic [7:0]     awlen, arlen, wstrb, reg_be;
   logic [2:0]     awsize, arsize;
   logic [1:0]     awburst, arburst, bresp, rresp;
   logic           awvalid, awready, arvalid, arready;
   logic           wlast, wvalid, wready, bvalid, bready;
   logic           rlast, rvalid, rready, reg_we;
   logic [63:0]    wdata, rdata, reg_wdata, reg_rdata;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  be;
      logic [63:0] data;
   } wr_t;
   typedef struct packed {
      logic [IDW-1:0] id;
      logic [1:0]     resp;
   } b_t;
   typedef struct packed {
      logic [IDW-1:0] id;
      logic [63:0]    data;
      logic [1:0]     resp;
      logic           last;
   } r_t;

   wr_t wr_q[$];
   b_t  b_q[$];
   r_t  r_q[$];
   wr_t ew;
   b_t  eb;
   r_t  er;
   r_t  held;
   logic stall_prev = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int aw_wait, ar_wait, ar_cyc;

   always #5 clk = ~clk;

   axi_reg_bridge #(.ID_WIDTH(IDW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize), .i_awburst(awburst),
      .i_awvalid(awvalid), .o_awready(awready),
      .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize), .i_arburst(arburst),
      .i_arvalid(arvalid), .o_arready(arready),
      .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid), .o_wready(wready),
      .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready),
      .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
      .i_rready(rready),
      .o_reg_we(reg_we), .o_reg_addr(reg_addr), .o_reg_be(reg_be), .o_reg_wdata(reg_wdata),
      .i_reg_rdata(reg_rdata)
   );

   function automatic logic [63:0] rf(input logic [31:0] a);
      return {~a, a ^ 32'h5A5A_C3C3};
   endfunction

   function automatic logic [31:0] adv(input logic [31:0] a, input logic [2:0] size,
                                       input logic [1:0] burst);
      return (burst == 2'b00) ? a : a + (32'd1 << size);
   endfunction

   // Register file model: data for whatever address the bridge is presenting.
   assign reg_rdata = rf(reg_addr);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(negedge clk);
      if (reg_we) begin
         check("we_pending", wr_q.size() > 0, 1'b1);
         if (wr_q.size() > 0) begin
            ew = wr_q.pop_front();
            check("we_addr", reg_addr, ew.addr);
            check("we_be", reg_be, ew.be);
            check("we_data", reg_wdata, ew.data);
         end
      end
      if (bvalid && bready) begin
         check("b_pending", b_q.size() > 0, 1'b1);
         if (b_q.size() > 0) begin
            eb = b_q.pop_front();
            check("b_id", bid, eb.id);
            check("b_resp", bresp, eb.resp);
         end
      end
      if (rvalid) begin
         if (stall_prev) begin
            check("r_hold_data", rdata, held.data);
            check("r_hold_ctl", {rid, rresp, rlast}, {held.id, held.resp, held.last});
         end
         if (rready) begin
            check("r_pending", r_q.size() > 0, 1'b1);
            if (r_q.size() > 0) begin
               er = r_q.pop_front();
               check("r_id", rid, er.id);
               check("r_data", rdata, er.data);
               check("r_resp", rresp, er.resp);
               check("r_last", rlast, er.last);
            end
         end
         stall_prev = !rready;
         held = '{id: rid, data: rdata, resp: rresp, last: rlast};
      end else begin
         if (stall_prev && rst_n) check("r_valid_held", rvalid, 1'b1);
         stall_prev = 1'b0;
      end
      if (awvalid && arvalid) check("one_grant", awready & arready, 1'b0);
   end

   task automatic send_aw(input logic [IDW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      awid = id; awaddr = a; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
      aw_wait = 0;
      do begin
         @(negedge clk);
         aw_wait++;
      end while (!awready && aw_wait < TMO);
      check("aw_handshake", awready, 1'b1);
      @(posedge clk);
      #1 awvalid = 1'b0;
   endtask

   task automatic send_ar(input logic [IDW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      arid = id; araddr = a; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
      ar_wait = 0;
      do begin
         @(negedge clk);
         ar_wait++;
      end while (!arready && ar_wait < TMO);
      check("ar_handshake", arready, 1'b1);
      ar_cyc = cyc;
      @(posedge clk);
      #1 arvalid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [63:0] d0, input logic [7:0] s0,
                         input int bad_last, input int nsend, output logic [1:0] resp);
      logic [31:0] cur;
      logic        err;
      int          n;
      cur = a;
      err = (burst == 2'b11);
      for (int i = 0; i < nsend; i++) begin
         wdata = d0 + 64'(i);
         wstrb = s0 ^ 8'(i);
         wlast = (bad_last >= 0) ? (i == bad_last) : (i == int'(len));
         if (wlast != (i == int'(len))) err = 1'b1;
         wr_q.push_back('{addr: cur & ~32'h7, be: wstrb, data: wdata});
         wvalid = 1'b1;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!wready && n < TMO);
         check("w_handshake", wready, 1'b1);
         @(posedge clk);
         #1 wvalid = 1'b0;
         cur = adv(cur, size, burst);
      end
      resp = err ? 2'b10 : 2'b00;
   endtask

   task automatic recv_b(input logic [IDW-1:0] id, input logic [1:0] resp);
      int n;
      b_q.push_back('{id: id, resp: resp});
      bready = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bvalid && n < TMO);
      check("b_valid", bvalid, 1'b1);
      @(negedge clk);
      check("b_valid_held", bvalid, 1'b1);
      @(posedge clk);
      #1 bready = 1'b1;
      @(negedge clk);
      check("b_handshake", bvalid, 1'b1);
      @(posedge clk);
      #1 bready = 1'b0;
   endtask

   task automatic recv_r(input logic [IDW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic toggle);
      logic [31:0] cur;
      logic        first;
      int          hs, n, nl;
      nl  = int'(len);
      cur = a;
      for (int i = 0; i <= nl; i++) begin
         r_q.push_back('{id: id, data: rf(cur & ~32'h7),
                         resp: (burst == 2'b11) ? 2'b10 : 2'b00, last: (i == nl)});
         cur = adv(cur, size, burst);
      end
      hs = 0;
      n = 0;
      first = 1'b1;
      while (hs <= nl && n < 20 * nl + TMO) begin
         rready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         n++;
         if (rvalid && first) begin
            check("r_latency", cyc - ar_cyc, 2);
            first = 1'b0;
         end
         if (rvalid && rready) hs++;
         @(posedge clk);
         #1;
      end
      rready = 1'b0;
      check("r_beats", hs, nl + 1);
   endtask

   task automatic axi_write(input logic [IDW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst,
                            input logic [63:0] d0, input logic [7:0] s0, input int bad_last);
      logic [1:0] resp;
      send_aw(id, a, len, size, burst);
      send_w(a, len, size, burst, d0, s0, bad_last, int'(len) + 1, resp);
      recv_b(id, resp);
   endtask

   task automatic axi_read(input logic [IDW-1:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic toggle);
      send_ar(id, a, len, size, burst);
      recv_r(id, a, len, size, burst, toggle);
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0] resp;
      rst_n = 1'b0;
      awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
      arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
      wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      bready = 1'b0; rready = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ctl", {awready, arready, wready, bvalid, rvalid, reg_we, rlast}, 7'b0);
      check("rst_reg_addr", reg_addr, 32'h0);
      check("rst_reg_be", reg_be, 8'h0);
      check("rst_reg_wdata", reg_wdata, 64'h0);
      check("rst_ids", {bid, rid}, 4'h0);
      check("rst_resp", {bresp, rresp}, 4'h0);
      check("rst_rdata", rdata, 64'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Simultaneous AW+AR straight after reset: write first, then read on the next tie.
      arid = 2'd3; araddr = 32'h40; arlen = 8'd0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b1;
      send_aw(2'd1, 32'h50, 8'd0, 3'd3, 2'b01);
      check("rr1_write_first", aw_wait, 1);
      send_w(32'h50, 8'd0, 3'd3, 2'b01, 64'hAAAA, 8'h0F, -1, 1, resp);
      recv_b(2'd1, resp);
      awid = 2'd2; awaddr = 32'h58; awlen = 8'd0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b1;
      send_ar(2'd3, 32'h40, 8'd0, 3'd3, 2'b01);
      check("rr2_read_first", ar_wait, 1);
      recv_r(2'd3, 32'h40, 8'd0, 3'd3, 2'b01, 1'b0);
      send_aw(2'd2, 32'h58, 8'd0, 3'd3, 2'b01);
      check("rr2_write_next", aw_wait, 1);
      send_w(32'h58, 8'd0, 3'd3, 2'b01, 64'hBBBB, 8'hF0, -1, 1, resp);
      recv_b(2'd2, resp);

      axi_write(2'd1, 32'h10, 8'd0, 3'd3, 2'b01, 64'h1, 8'hFF, -1);
      axi_read(2'd2, 32'h20, 8'd0, 3'd3, 2'b01, 1'b0);
      axi_read(2'd0, 32'h0, 8'd3, 3'd3, 2'b01, 1'b1);
      axi_write(2'd3, 32'h28, 8'd2, 3'd3, 2'b00, 64'h100, 8'h3C, -1);
      axi_write(2'd3, 32'h28, 8'd2, 3'd3, 2'b00, 64'h200, 8'hC3, 1);
      axi_write(2'd0, 32'h4, 8'd2, 3'd2, 2'b01, 64'h300, 8'h0F, -1);
      axi_write(2'd1, 32'h60, 8'd1, 3'd3, 2'b11, 64'h400, 8'hFF, -1);
      axi_read(2'd1, 32'h4, 8'd1, 3'd2, 2'b11, 1'b1);
      axi_read(2'd2, 32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0);
      axi_read(2'd3, 32'h30, 8'd2, 3'd3, 2'b00, 1'b1);
      axi_read(2'd0, 32'h80, 8'd3, 3'd3, 2'b10, 1'b1);
      axi_write(2'd2, 32'h1000, 8'd255, 3'd3, 2'b01, 64'h5000, 8'h81, -1);

      // Reset after the second beat of a four-beat write.
      send_aw(2'd2, 32'h100, 8'd3, 3'd3, 2'b01);
      send_w(32'h100, 8'd3, 3'd3, 2'b01, 64'h77, 8'hFF, -1, 2, resp);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("arst_we", reg_we, 1'b0);
      check("arst_ctl", {awready, arready, wready, bvalid, rvalid, rlast}, 6'b0);
      check("arst_reg_addr", reg_addr, 32'h0);
      check("arst_reg_be", reg_be, 8'h0);
      check("arst_reg_wdata", reg_wdata, 64'h0);
      check("arst_bid", bid, 2'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wdata = 64'hDEAD; wstrb = 8'hFF; wlast = 1'b1; wvalid = 1'b1;
      repeat (2) @(negedge clk);
      check("post_rst_wready", wready, 1'b0);
      @(posedge clk);
      #1 wvalid = 1'b0;
      axi_write(2'd1, 32'h200, 8'd1, 3'd3, 2'b01, 64'h900, 8'h55, -1);

      repeat (3) @(posedge clk);
      check("wr_q_empty", wr_q.size(), 0);
      check("b_q_empty", b_q.size(), 0);
      check("r_q_empty", r_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
